// File: rtl/fm_pkg.sv
// Shared widths, quadrant encoding and the quarter-wave sine table generator
// used by both the modulator RTL and its reference bench.
package fm_pkg;

    localparam int DEF_PHASE_W   = 32;
    localparam int DEF_AUDIO_W   = 16;
    localparam int DEF_LUT_AW    = 10;
    localparam int DEF_OUT_W     = 16;
    localparam int DEF_DEV_SHIFT = 4;

    // Phase MSBs: bit 0 mirrors the table address, bit 1 negates the output.
    localparam logic [1:0] QUAD_RISE     = 2'd0;
    localparam logic [1:0] QUAD_FALL     = 2'd1;
    localparam logic [1:0] QUAD_NEG_FALL = 2'd2;
    localparam logic [1:0] QUAD_NEG_RISE = 2'd3;

    // round((2^(outW-1)-1) * sin(pi/2 * (idx+0.5) / 2^lutAw)) via a Taylor series,
    // sampled at half-step offsets so mirrored addresses stay exactly symmetric.
    function automatic int sineRomEntry(input int idx, input int lutAw, input int outW);
        real x;
        real term;
        real acc;
        int  v;
        x    = 1.5707963267948966 * (real'(idx) + 0.5) / real'(1 << lutAw);
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        v = $rtoi(acc * real'((1 << (outW - 1)) - 1) + 0.5);
        return v;
    endfunction

endpackage

// File: rtl/fm_modulator_sine_lut_quarter.sv
// Registered quarter-wave sine ROM: 2^LUT_AW unsigned magnitudes of OUT_W-1 bits,
// one clock of read latency, no reset so it maps onto block RAM.
module sine_lut_quarter
    import fm_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  data
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [OUT_W-2:0] romTable [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : gRom
        localparam int ENTRY = sineRomEntry(g, LUT_AW, OUT_W);
        assign romTable[g] = ENTRY[OUT_W-2:0];
    end

    always_ff @(posedge clk) begin
        data <= romTable[addr];
    end

endmodule

// File: rtl/fm_modulator.sv
// Direct-digital FM modulator: audio sets the phase increment around a carrier word,
// the phase accumulator addresses a quarter-wave sine table to give signed samples.
module fm_modulator
    import fm_pkg::*;
#(
    parameter int PHASE_W   = DEF_PHASE_W,
    parameter int AUDIO_W   = DEF_AUDIO_W,
    parameter int LUT_AW    = DEF_LUT_AW,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int DEV_SHIFT = DEF_DEV_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic signed [AUDIO_W-1:0] audio_in,
    input  logic                      audio_valid,
    input  logic        [PHASE_W-1:0] carrier_inc,
    input  logic        [15:0]        dev_gain,
    output logic signed [OUT_W-1:0]   out_sample,
    output logic                      out_valid,
    output logic        [PHASE_W-1:0] phase_out
);

    localparam int PROD_W = AUDIO_W + 17;

    logic signed [AUDIO_W-1:0] audio_q, audio_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [PROD_W-1:0]  devShift;
    logic        [PHASE_W-1:0] inc_q, inc_d;
    logic        [PHASE_W-1:0] phase_q, phase_d;
    logic                      en_q;
    logic        [1:0]         quad_q, quad_d;
    logic        [LUT_AW-1:0]  addr_q, addr_d;
    logic        [1:0]         quadLut_q;
    logic        [OUT_W-2:0]   lutData;
    logic signed [OUT_W-1:0]   out_q, out_d;
    logic                      valid1_q, valid2_q, valid_q;

    // Gain is unsigned, so it gets a zero MSB before the signed multiply.
    always_comb begin
        audio_d  = audio_valid ? audio_in : audio_q;
        prod_d   = PROD_W'(audio_q) * PROD_W'($signed({1'b0, dev_gain}));
        devShift = prod_q >>> DEV_SHIFT;
        inc_d    = carrier_inc + PHASE_W'(devShift);
        phase_d  = enable ? (phase_q + inc_q) : phase_q;
        quad_d   = phase_q[PHASE_W-1 -: 2];
        addr_d   = quad_d[0] ? ~phase_q[PHASE_W-3 -: LUT_AW] : phase_q[PHASE_W-3 -: LUT_AW];
        out_d    = quadLut_q[1] ? -$signed({1'b0, lutData}) : $signed({1'b0, lutData});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_q   <= '0;
            prod_q    <= '0;
            inc_q     <= '0;
            phase_q   <= '0;
            en_q      <= 1'b0;
            quad_q    <= QUAD_RISE;
            addr_q    <= '0;
            quadLut_q <= QUAD_RISE;
            out_q     <= '0;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            audio_q   <= audio_d;
            prod_q    <= prod_d;
            inc_q     <= inc_d;
            phase_q   <= phase_d;
            en_q      <= enable;
            quad_q    <= quad_d;
            addr_q    <= addr_d;
            quadLut_q <= quad_q;
            out_q     <= out_d;
            valid1_q  <= en_q;
            valid2_q  <= valid1_q;
            valid_q   <= valid2_q;
        end
    end

    sine_lut_quarter #(
        .LUT_AW(LUT_AW),
        .OUT_W (OUT_W)
    ) uSineLut (
        .clk (clk),
        .addr(addr_q),
        .data(lutData)
    );

    assign out_sample = out_q;
    assign out_valid  = valid_q;
    assign phase_out  = phase_q;

endmodule

// File: tb/tb_fm_modulator.sv
// Directed bench for fm_modulator: carrier stepping, audio deviation, wrap,
// enable gating and asynchronous reset, all against hand-computed values.
module tb_fm_modulator;
    timeunit 1ns;
    timeprecision 100ps;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] audio_in = '0;
    logic               audio_valid = 1'b0;
    logic        [31:0] carrier_inc = '0;
    logic        [15:0] dev_gain = '0;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic        [31:0] phase_out;

    bit clkRun = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        [31:0] phase;
        logic signed [15:0] sample;
        logic               valid;
    } vec_t;

    vec_t vecs[8];
    int   exp3[14];

    fm_modulator dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .audio_in   (audio_in),
        .audio_valid(audio_valid),
        .carrier_inc(carrier_inc),
        .dev_gain   (dev_gain),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .phase_out  (phase_out)
    );

    always #5 if (clkRun) clk = ~clk;

    task automatic applyStimulus(input logic en, input logic signed [15:0] aIn, input logic aValid,
                                 input logic [31:0] carrier, input logic [15:0] gain);
        enable      = en;
        audio_in    = aIn;
        audio_valid = aValid;
        carrier_inc = carrier;
        dev_gain    = gain;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ePh,
                               input logic signed [15:0] eSm, input logic eVal, input bit doSm);
        checks++;
        if (phase_out !== ePh) begin
            errors++;
            $display("[TB] FAIL %s phase_out got %h want %h", name, phase_out, ePh);
        end
        checks++;
        if (out_valid !== eVal) begin
            errors++;
            $display("[TB] FAIL %s out_valid got %b want %b", name, out_valid, eVal);
        end
        if (doSm) begin
            checks++;
            if (out_sample !== eSm) begin
                errors++;
                $display("[TB] FAIL %s out_sample got %0d want %0d", name, out_sample, eSm);
            end
        end
    endtask

    initial begin
        #50000;
        errors++;
        $display("[TB] FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vecs[0] = '{32'h4000_0000,     25, 1'b0};
        vecs[1] = '{32'h8000_0000,     25, 1'b0};
        vecs[2] = '{32'hC000_0000,     25, 1'b0};
        vecs[3] = '{32'h0000_0000,  32767, 1'b1};
        vecs[4] = '{32'h4000_0000,    -25, 1'b1};
        vecs[5] = '{32'h8000_0000, -32767, 1'b1};
        vecs[6] = '{32'hC000_0000,     25, 1'b1};
        vecs[7] = '{32'h0000_0000,  32767, 1'b1};
        exp3 = '{0, 0, 0, 1000, 2000, 3000, 4000, 5000, 4000, 3000, 2000, 1000, 0, -1000};

        $display("[TB] reset with clock stopped");
        #2 rst = 1'b1;
        #0.2;
        checkOutput("asyncRstNoClk", 32'h0, 16'sd0, 1'b0, 1'b1);

        $display("[TB] carrier quarter-turn stepping");
        applyStimulus(1'b0, 16'sd0, 1'b0, 32'h4000_0000, 16'd0);
        clkRun = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        applyStimulus(1'b1, 16'sd0, 1'b0, 32'h4000_0000, 16'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("carrierStep[%0d]", k + 1), vecs[k].phase, vecs[k].sample,
                        vecs[k].valid, 1'b1);
        end

        $display("[TB] enable low for ten clocks");
        tick();
        checkOutput("preFreeze", 32'h4000_0000, -16'sd25, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'sd0, 1'b0, 32'h4000_0000, 16'd0);
        tick();
        checkOutput("freeze1", 32'h4000_0000, -16'sd32767, 1'b1, 1'b1);
        tick();
        checkOutput("freeze2", 32'h4000_0000, 16'sd25, 1'b1, 1'b1);
        tick();
        checkOutput("freeze3", 32'h4000_0000, 16'sd32767, 1'b1, 1'b1);
        tick();
        checkOutput("freezeValidFall", 32'h4000_0000, 16'sd32767, 1'b0, 1'b1);
        for (int n = 14; n <= 19; n++) begin
            tick();
            checkOutput($sformatf("frozen[%0d]", n), 32'h4000_0000, 16'sd32767, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 16'sd0, 1'b0, 32'h4000_0000, 16'd0);
        tick();
        checkOutput("resume1", 32'h8000_0000, 16'sd32767, 1'b0, 1'b1);
        tick();
        checkOutput("resume2", 32'hC000_0000, 16'sd32767, 1'b0, 1'b1);
        tick();
        checkOutput("resume3", 32'h0000_0000, 16'sd32767, 1'b0, 1'b1);
        tick();
        checkOutput("resumeValidRise", 32'h4000_0000, -16'sd25, 1'b1, 1'b1);

        $display("[TB] asynchronous reset mid-stream");
        #1 rst = 1'b1;
        #0.2;
        checkOutput("midRstImmediate", 32'h0, 16'sd0, 1'b0, 1'b1);
        #0.8 rst = 1'b0;
        tick();
        checkOutput("restart1", 32'h0000_0000, 16'sd0, 1'b0, 1'b0);
        tick();
        checkOutput("restart2", 32'h4000_0000, 16'sd25, 1'b0, 1'b1);
        tick();
        checkOutput("restart3", 32'h8000_0000, 16'sd25, 1'b0, 1'b1);
        tick();
        checkOutput("restart4", 32'hC000_0000, 16'sd25, 1'b1, 1'b1);
        tick();
        checkOutput("restart5", 32'h0000_0000, 16'sd32767, 1'b1, 1'b1);
        tick();
        checkOutput("restart6", 32'h4000_0000, -16'sd25, 1'b1, 1'b1);

        $display("[TB] audio deviation up then down");
        applyStimulus(1'b1, 16'sd1000, 1'b1, 32'h0, 16'd16);
        doReset();
        for (int i = 0; i < 14; i++) begin
            if (i == 5) applyStimulus(1'b1, -16'sd1000, 1'b1, 32'h0, 16'd16);
            tick();
            applyStimulus(1'b1, 16'sh7FFF, 1'b0, 32'h0, 16'd16);
            checkOutput($sformatf("deviation[%0d]", i), 32'(exp3[i]), 16'sd25, (i >= 3),
                        (i >= 1));
        end

        $display("[TB] all-ones carrier runs backward");
        applyStimulus(1'b0, 16'sd0, 1'b0, 32'hFFFF_FFFF, 16'd0);
        doReset();
        tick();
        tick();
        applyStimulus(1'b1, 16'sd0, 1'b0, 32'hFFFF_FFFF, 16'd0);
        tick();
        checkOutput("wrap1", 32'hFFFF_FFFF, 16'sd25, 1'b0, 1'b1);
        tick();
        checkOutput("wrap2", 32'hFFFF_FFFE, 16'sd25, 1'b0, 1'b1);
        tick();
        checkOutput("wrap3", 32'hFFFF_FFFD, 16'sd25, 1'b0, 1'b1);
        tick();
        checkOutput("wrap4", 32'hFFFF_FFFC, -16'sd25, 1'b1, 1'b1);
        tick();
        checkOutput("wrap5", 32'hFFFF_FFFB, -16'sd25, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
